// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM unified memory port arbiter.
// Default widths and the streak counter width live here.
package mem_arb_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  localparam int SW     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_sel.sv
// arb_priority_sel: data-first owner pick with a streak limit.
// The streak only advances when data wins over a waiting fetch.
module arb_priority_sel
  import mem_arb_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic          if_req,
  input  logic          d_req,
  input  logic [SW-1:0] streak,
  output owner_e        owner,
  output logic [SW-1:0] streak_nxt
);

  localparam logic [SW-1:0] LIM = SW'(MAX_STREAK);
  localparam logic [SW-1:0] ONE = SW'(1);

  logic both;
  logic starve;

  assign both   = if_req && d_req;
  assign starve = streak >= LIM;

  always_comb begin
    owner      = OWN_IF;
    streak_nxt = streak;
    unique case (1'b1)
      both && !starve: begin
        owner      = OWN_D;
        streak_nxt = streak + ONE;
      end
      both && starve: begin
        owner      = OWN_IF;
        streak_nxt = '0;
      end
      d_req && !if_req: begin
        owner      = OWN_D;
        streak_nxt = '0;
      end
      if_req && !d_req: begin
        owner      = OWN_IF;
        streak_nxt = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// IF/MEM arbiter for one single-port memory, one transaction at a time.
// Optional perf counters under ARB_PERF_CNT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int MAX_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy,
  output logic [31:0]     conflict_cnt
);

  arb_state_e    state;
  owner_e        owner;
  logic [SW-1:0] streak;
  owner_e        sel_owner;
  logic [SW-1:0] sel_streak;
  logic          in_req;
  logic          done;
  logic          own_d;

  arb_priority_sel #(
    .MAX_STREAK(MAX_STREAK)
  ) u_sel (
    .if_req    (if_req),
    .d_req     (d_req),
    .streak    (streak),
    .owner     (sel_owner),
    .streak_nxt(sel_streak)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      streak    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state  <= REQ;
            owner  <= sel_owner;
            streak <= sel_streak;
            if (sel_owner == OWN_D) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_wstrb <= d_wstrb;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_wstrb <= '1;
            end
          end
        end
        REQ:     if (mem_gnt) state <= RESP;
        RESP:    if (mem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by rst so an aborted transaction never signals the requester
  assign in_req    = !rst && (state == REQ);
  assign done      = !rst && (state == RESP) && mem_rvalid;
  assign own_d     = (owner == OWN_D);
  assign mem_req   = in_req;
  assign if_gnt    = in_req && mem_gnt && !own_d;
  assign d_gnt     = in_req && mem_gnt && own_d;
  assign if_rvalid = done && !own_d;
  assign d_rvalid  = done && own_d;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid && !mem_we) ? mem_rdata : '0;
  assign busy      = (state != IDLE);

`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_q;
  logic [31:0] fetch_wait_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q   <= '0;
      fetch_wait_q <= '0;
    end else begin
      if (if_req && d_req && !if_gnt && !d_gnt)
        conflict_q <= conflict_q + 32'd1;
      if (if_req && !if_gnt)
        fetch_wait_q <= fetch_wait_q + 32'd1;
    end
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = '0;
`endif

  a_if_hold: assert property (@(posedge clk) disable iff (rst)
    (if_req && !if_gnt) |=> (if_req && $stable(if_addr)));

  a_d_hold: assert property (@(posedge clk) disable iff (rst)
    (d_req && !d_gnt) |=> (d_req && $stable(d_we) &&
      $stable(d_addr) && $stable(d_wdata) && $stable(d_wstrb)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus
// starvation, reset-abort and conflict-counter sequences.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [31:0] conflict_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_gnt      (if_gnt),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_wstrb     (d_wstrb),
    .d_gnt       (d_gnt),
    .d_rvalid    (d_rvalid),
    .d_rdata     (d_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .conflict_cnt(conflict_cnt)
  );

  // ctl = {if_req, d_req, d_we, mem_gnt, mem_rvalid}
  // ectl = {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, busy}
  typedef struct {
    string       nm;
    logic [4:0]  ctl;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] dd;
    logic [3:0]  ds;
    logic [31:0] md;
    logic [6:0]  ectl;
    logic [31:0] eid;
    logic [31:0] edd;
    logic [31:0] ema;
    logic [31:0] emd;
    logic [3:0]  ems;
  } vec_t;

  vec_t vt [16];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    if_req     = 1'b0;
    if_addr    = '0;
    d_req      = 1'b0;
    d_we       = 1'b0;
    d_addr     = '0;
    d_wdata    = '0;
    d_wstrb    = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_in();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic apply(vec_t v);
    {if_req, d_req, d_we, mem_gnt, mem_rvalid} = v.ctl;
    if_addr   = v.ia;
    d_addr    = v.da;
    d_wdata   = v.dd;
    d_wstrb   = v.ds;
    mem_rdata = v.md;
  endtask

  task automatic check_vec(vec_t v);
    chk({v.nm, ".if_gnt"}, 32'(if_gnt), 32'(v.ectl[6]));
    chk({v.nm, ".if_rvalid"}, 32'(if_rvalid), 32'(v.ectl[5]));
    chk({v.nm, ".d_gnt"}, 32'(d_gnt), 32'(v.ectl[4]));
    chk({v.nm, ".d_rvalid"}, 32'(d_rvalid), 32'(v.ectl[3]));
    chk({v.nm, ".mem_req"}, 32'(mem_req), 32'(v.ectl[2]));
    chk({v.nm, ".busy"}, 32'(busy), 32'(v.ectl[0]));
    chk({v.nm, ".if_rdata"}, if_rdata, v.eid);
    chk({v.nm, ".d_rdata"}, d_rdata, v.edd);
    if (v.ectl[2]) begin
      chk({v.nm, ".mem_we"}, 32'(mem_we), 32'(v.ectl[1]));
      chk({v.nm, ".mem_addr"}, mem_addr, v.ema);
      chk({v.nm, ".mem_wdata"}, mem_wdata, v.emd);
      chk({v.nm, ".mem_wstrb"}, 32'(mem_wstrb), 32'(v.ems));
    end
  endtask

  logic [9:0] got_ord;
  logic [9:0] exp_ord;
  int         ng;
  logic       g_i;
  logic       g_d;
  logic       drained;
  int         exp_conf;

  initial begin
    vt[0]  = '{"f_idle", 5'b10000, 32'h100, 0, 0, 4'h0, 0,
               7'b0000000, 0, 0, 0, 0, 4'h0};
    vt[1]  = '{"f_req", 5'b10010, 32'h100, 0, 0, 4'h0, 0,
               7'b1000101, 0, 0, 32'h100, 0, 4'hF};
    vt[2]  = '{"f_resp", 5'b00001, 0, 0, 0, 4'h0, 32'h00500093,
               7'b0100001, 32'h00500093, 0, 0, 0, 4'h0};
    vt[3]  = '{"f_done", 5'b00000, 0, 0, 0, 4'h0, 0,
               7'b0000000, 0, 0, 0, 0, 4'h0};
    vt[4]  = '{"w_idle", 5'b01100, 0, 32'h2000, 32'hDEADBEEF, 4'hF, 0,
               7'b0000000, 0, 0, 0, 0, 4'h0};
    vt[5]  = '{"w_req", 5'b01110, 0, 32'h2000, 32'hDEADBEEF, 4'hF, 0,
               7'b0010111, 0, 0, 32'h2000, 32'hDEADBEEF, 4'hF};
    vt[6]  = '{"w_resp", 5'b00001, 0, 0, 0, 4'h0, 32'h12345678,
               7'b0001001, 0, 0, 0, 0, 4'h0};
    vt[7]  = '{"w_done", 5'b00000, 0, 0, 0, 4'h0, 0,
               7'b0000000, 0, 0, 0, 0, 4'h0};
    vt[8]  = '{"r_idle", 5'b01000, 0, 32'h3004, 0, 4'h3, 0,
               7'b0000000, 0, 0, 0, 0, 4'h0};
    vt[9]  = '{"r_wait1", 5'b01000, 0, 32'h3004, 0, 4'h3, 0,
               7'b0000101, 0, 0, 32'h3004, 0, 4'h3};
    vt[10] = '{"r_wait2", 5'b01001, 0, 32'h3004, 0, 4'h3, 32'h77777777,
               7'b0000101, 0, 0, 32'h3004, 0, 4'h3};
    vt[11] = '{"r_wait3", 5'b01000, 0, 32'h3004, 0, 4'h3, 0,
               7'b0000101, 0, 0, 32'h3004, 0, 4'h3};
    vt[12] = '{"r_gnt", 5'b01011, 0, 32'h3004, 0, 4'h3, 32'hAAAA5555,
               7'b0010101, 0, 0, 32'h3004, 0, 4'h3};
    vt[13] = '{"r_resp0", 5'b00000, 0, 0, 0, 4'h0, 0,
               7'b0000001, 0, 0, 0, 0, 4'h0};
    vt[14] = '{"r_resp1", 5'b00001, 0, 0, 0, 4'h0, 32'hCAFEF00D,
               7'b0001001, 0, 32'hCAFEF00D, 0, 0, 4'h0};
    vt[15] = '{"r_idle_rv", 5'b00001, 0, 0, 0, 4'h0, 32'h55555555,
               7'b0000000, 0, 0, 0, 0, 4'h0};

    rst = 1'b1;
    idle_in();
    @(posedge clk);
    @(negedge clk);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.mem_req", 32'(mem_req), 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_wstrb", 32'(mem_wstrb), 0);
    chk("rst.gnt", 32'({if_gnt, d_gnt}), 0);
    chk("rst.rvalid", 32'({if_rvalid, d_rvalid}), 0);
    chk("rst.rdata", if_rdata | d_rdata, 0);
    chk("rst.conflict", conflict_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      apply(vt[i]);
      @(negedge clk);
      check_vec(vt[i]);
      @(posedge clk); #1;
    end

    // Both requesters saturating the port
    pulse_rst();
    if_req     = 1'b1;
    if_addr    = 32'h1000;
    d_req      = 1'b1;
    d_addr     = 32'h4000;
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11;
    exp_ord    = 10'b0111101111;
    got_ord    = '0;
    ng         = 0;
    for (int c = 0; c < 40 && ng < 10; c++) begin
      @(negedge clk);
      chk("stv.gnt_excl", 32'(if_gnt && d_gnt), 0);
      g_i = if_gnt;
      g_d = d_gnt;
      if (g_i || g_d) begin
        got_ord[ng] = g_d;
        ng++;
      end
      @(posedge clk); #1;
      if (g_i) if_addr = if_addr + 32'd4;
      if (g_d) d_addr = d_addr + 32'd4;
    end
    chk("stv.grants", 32'(ng), 10);
    chk("stv.order", 32'(got_ord), 32'(exp_ord));
    if_req  = 1'b0;
    drained = 1'b0;
    for (int c = 0; c < 10 && !drained; c++) begin
      @(negedge clk);
      if (d_gnt) drained = 1'b1;
      @(posedge clk); #1;
    end
    chk("stv.drain", 32'(drained), 1);
    d_req = 1'b0;

    // Reset while waiting for the response
    pulse_rst();
    if_req  = 1'b1;
    if_addr = 32'h200;
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("rr.if_gnt", 32'(if_gnt), 1);
    @(posedge clk); #1;
    if_req  = 1'b0;
    mem_gnt = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    chk("rr.rv_in_rst", 32'(if_rvalid), 0);
    @(posedge clk); #1;
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0BAD0;
    @(negedge clk);
    chk("rr.stale_if", 32'(if_rvalid), 0);
    chk("rr.stale_d", 32'(d_rvalid), 0);
    chk("rr.stale_data", if_rdata, 0);
    chk("rr.idle", 32'(busy), 0);

    // Reset while requesting, then the same fetch completes
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    if_req     = 1'b1;
    if_addr    = 32'h300;
    @(posedge clk); #1;
    rst     = 1'b1;
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("rq.no_gnt", 32'(if_gnt), 0);
    chk("rq.no_req", 32'(mem_req), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rq.idle", 32'(busy), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rq.mem_req", 32'(mem_req), 1);
    chk("rq.mem_addr", mem_addr, 32'h300);
    chk("rq.if_gnt", 32'(if_gnt), 1);
    @(posedge clk); #1;
    if_req     = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h00A00113;
    @(negedge clk);
    chk("rq.if_rvalid", 32'(if_rvalid), 1);
    chk("rq.if_rdata", if_rdata, 32'h00A00113);
    chk("rq.d_rvalid", 32'(d_rvalid), 0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;

    // Ten cycles of dual request with the memory never granting
    pulse_rst();
    if_req  = 1'b1;
    if_addr = 32'h500;
    d_req   = 1'b1;
    d_addr  = 32'h6000;
`ifdef ARB_PERF_CNT_EN
    exp_conf = 10;
`else
    exp_conf = 0;
`endif
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("pc.conflict", conflict_cnt, 32'(exp_conf));
    chk("pc.d_owner_req", 32'(mem_req), 1);
    chk("pc.d_addr", mem_addr, 32'h6000);
    chk("pc.no_gnt", 32'({if_gnt, d_gnt}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
